// File: rtl/unidade_mult_div.sv
// rtl/unidade_mult_div.sv - iterative unsigned multiply/divide unit, one bit per clock
module unidade_mult_div #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] operando_a,
    input  logic [DATA_WIDTH-1:0] operando_b,
    input  logic [1:0]            operacao,
    input  logic                  inicio,
    output logic                  ocupado,
    output logic                  pronto,
    output logic [DATA_WIDTH-1:0] resultado,
    output logic                  div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        PRONTO
    } estado_t;

    estado_t         estado_q;
    logic [W:0]      acc_hi_q;     // product high half, or partial remainder
    logic [W-1:0]    acc_lo_q;     // multiplier / product low half, or dividend / quotient
    logic [W-1:0]    oper_q;       // multiplicand or divisor
    logic [1:0]      operacao_q;
    logic            dz_q;
    logic [CW-1:0]   cont_q;

    logic [W:0]      acc_hi_d;
    logic [W-1:0]    acc_lo_d;
    logic [W-1:0]    resultado_d;
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic [W:0]      div_diff;
    logic            div_ge;

    always_comb begin
        mul_sum   = acc_hi_q + (acc_lo_q[0] ? {1'b0, oper_q} : '0);
        div_shift = {acc_hi_q[W-1:0], acc_lo_q[W-1]};
        div_diff  = div_shift - {1'b0, oper_q};
        div_ge    = (div_shift >= {1'b0, oper_q});
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        if (!operacao_q[1]) begin
            acc_hi_d = {1'b0, mul_sum[W:1]};
            acc_lo_d = {mul_sum[0], acc_lo_q[W-1:1]};
        end else if (div_ge) begin
            acc_hi_d = div_diff;
            acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
        end else begin
            acc_hi_d = div_shift;
            acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
        end

        // With a zero divisor every trial succeeds, so the remainder ends up as the dividend.
        resultado_d = '0;
        case (operacao_q)
            2'b00:   resultado_d = acc_lo_d;
            2'b01:   resultado_d = acc_hi_d[W-1:0];
            2'b10:   resultado_d = dz_q ? '1 : acc_lo_d;
            default: resultado_d = acc_hi_d[W-1:0];
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
            resultado  <= '0;
            div_zero   <= 1'b0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            oper_q     <= '0;
            operacao_q <= 2'b00;
            dz_q       <= 1'b0;
            cont_q     <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    pronto <= 1'b0;
                    if (inicio) begin
                        operacao_q <= operacao;
                        dz_q       <= operacao[1] && (operando_b == '0);
                        acc_hi_q   <= '0;
                        oper_q     <= operacao[1] ? operando_b : operando_a;
                        acc_lo_q   <= operacao[1] ? operando_a : operando_b;
                        cont_q     <= CW'(DATA_WIDTH);
                        ocupado    <= 1'b1;
                        estado_q   <= CALCULA;
                    end
                end
                CALCULA: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cont_q   <= cont_q - CW'(1);
                    if (cont_q == CW'(1)) begin
                        resultado <= resultado_d;
                        div_zero  <= dz_q;
                        pronto    <= 1'b1;
                        estado_q  <= PRONTO;
                    end
                end
                PRONTO: begin
                    pronto   <= 1'b0;
                    ocupado  <= 1'b0;
                    estado_q <= OCIOSO;
                end
                default: begin
                    pronto   <= 1'b0;
                    ocupado  <= 1'b0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

endmodule
